// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, branch condition codes, flag update masks
// and the flag controller state type.
package cpu_pkg;

    localparam int unsigned OPC_W   = 4;
    localparam int unsigned CC_BITS = 3;

    localparam logic [OPC_W-1:0] ADD = 4'h0;
    localparam logic [OPC_W-1:0] SUB = 4'h1;
    localparam logic [OPC_W-1:0] XOR = 4'h2;
    localparam logic [OPC_W-1:0] SLL = 4'h3;
    localparam logic [OPC_W-1:0] SRA = 4'h4;
    localparam logic [OPC_W-1:0] ROR = 4'h5;
    localparam logic [OPC_W-1:0] B   = 4'h6;
    localparam logic [OPC_W-1:0] BR  = 4'h7;
    localparam logic [OPC_W-1:0] HLT = 4'hF;

    localparam logic [CC_BITS-1:0] CC_NE = 3'b000;
    localparam logic [CC_BITS-1:0] CC_EQ = 3'b001;
    localparam logic [CC_BITS-1:0] CC_GT = 3'b010;
    localparam logic [CC_BITS-1:0] CC_LT = 3'b011;
    localparam logic [CC_BITS-1:0] CC_GE = 3'b100;
    localparam logic [CC_BITS-1:0] CC_LE = 3'b101;
    localparam logic [CC_BITS-1:0] CC_OV = 3'b110;
    localparam logic [CC_BITS-1:0] CC_AL = 3'b111;

    typedef enum logic {RUN, HALTED} flag_state_t;

    // Returns the {N,Z,V} bits an opcode is allowed to write.
    function automatic logic [2:0] flag_mask(input logic [OPC_W-1:0] opcode);
        logic [2:0] m;
        m = 3'b000;
        case (opcode)
            ADD, SUB:           m = 3'b111;
            XOR, SLL, SRA, ROR: m = 3'b010;
            default:            m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluation on {N,Z,V} flags.
module branch_cond_eval
    import cpu_pkg::*;
#(
    parameter int unsigned CC_W = 3
) (
    input  logic [2:0]      eff,
    input  logic [CC_W-1:0] br_cond,
    output logic            cond_true
);

    logic n, z, v;
    assign {n, z, v} = eff;

    always_comb begin
        cond_true = 1'b0;
        case (br_cond)
            CC_NE: cond_true = !z;
            CC_EQ: cond_true = z;
            CC_GT: cond_true = !z && !n;
            CC_LT: cond_true = n;
            CC_GE: cond_true = z || (!z && !n);
            CC_LE: cond_true = n || z;
            CC_OV: cond_true = v;
            CC_AL: cond_true = 1'b1;
        endcase
    end

endmodule

// File: rtl/flag_ctrl.sv
// Architectural N/Z/V flag owner: masked flag commit from EX, EX-to-ID bypass,
// branch hazard/resolve for ID, and a sticky halt state.
module flag_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned OPCODE_W = 4,
    parameter int unsigned CC_W     = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_valid,
    input  logic                ex_stall,
    input  logic                ex_flush,
    input  logic [OPCODE_W-1:0] ex_opcode,
    input  logic [2:0]          ex_flags,
    input  logic                br_valid,
    input  logic [CC_W-1:0]     br_cond,
    output logic                br_ready,
    output logic                br_taken,
    output logic                N_flag,
    output logic                Z_flag,
    output logic                V_flag,
    output logic                halted
);

    flag_state_t state_q, state_d;
    logic [2:0]  flags_q, flags_d;
    logic [2:0]  mask;
    logic [2:0]  eff;
    logic        commit;
    logic        hazard;
    logic        cond_true;

    assign mask   = flag_mask(ex_opcode);
    assign commit = ex_valid && !ex_stall && !ex_flush && (state_q == RUN);

    // Committing writer's bits are forwarded so ID sees them this cycle.
    assign eff = commit ? ((ex_flags & mask) | (flags_q & ~mask)) : flags_q;

    // A stalled flag writer has not produced final flags yet; a flushed one never will.
    assign hazard = ex_valid && !ex_flush && ex_stall && (mask != 3'b000);

    always_comb begin
        flags_d = eff;
        state_d = state_q;
        if (commit && (ex_opcode == HLT)) begin
            state_d = HALTED;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= 3'b000;
            state_q <= RUN;
        end else begin
            flags_q <= flags_d;
            state_q <= state_d;
        end
    end

    branch_cond_eval #(
        .CC_W (CC_W)
    ) u_cond (
        .eff       (eff),
        .br_cond   (br_cond),
        .cond_true (cond_true)
    );

    assign br_ready = (state_q == RUN) && !hazard;
    assign br_taken = br_valid && br_ready && cond_true;

    assign {N_flag, Z_flag, V_flag} = flags_q;
    assign halted = (state_q == HALTED);

endmodule

// File: tb/tb_flag_ctrl.sv
// Directed and randomized bench for flag_ctrl against a flag-level reference model.
module tb_flag_ctrl;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       ex_valid, ex_stall, ex_flush;
    logic [3:0] ex_opcode;
    logic [2:0] ex_flags;
    logic       br_valid;
    logic [2:0] br_cond;
    logic       br_ready, br_taken;
    logic       N_flag, Z_flag, V_flag, halted;

    int n_cmp = 0;
    int n_err = 0;

    bit m_n, m_z, m_v, m_halt;
    bit obs_rdy, obs_tk;

    always #5 clk = ~clk;

    flag_ctrl #(
        .OPCODE_W (4),
        .CC_W     (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ex_valid  (ex_valid),
        .ex_stall  (ex_stall),
        .ex_flush  (ex_flush),
        .ex_opcode (ex_opcode),
        .ex_flags  (ex_flags),
        .br_valid  (br_valid),
        .br_cond   (br_cond),
        .br_ready  (br_ready),
        .br_taken  (br_taken),
        .N_flag    (N_flag),
        .Z_flag    (Z_flag),
        .V_flag    (V_flag),
        .halted    (halted)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit writes_z(input logic [3:0] op);
        return op == ADD || op == SUB || op == XOR || op == SLL || op == SRA || op == ROR;
    endfunction

    function automatic bit writes_nv(input logic [3:0] op);
        return op == ADD || op == SUB;
    endfunction

    function automatic bit cond_of(input logic [2:0] cc, input bit n, input bit z, input bit v);
        case (cc)
            3'd0:    return !z;
            3'd1:    return z;
            3'd2:    return !(z || n);
            3'd3:    return n;
            3'd4:    return z || !n;
            3'd5:    return n || z;
            3'd6:    return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic drive(input bit v, input bit s, input bit f, input logic [3:0] op,
                         input logic [2:0] fl, input bit bv, input logic [2:0] cc);
        ex_valid  = v;
        ex_stall  = s;
        ex_flush  = f;
        ex_opcode = op;
        ex_flags  = fl;
        br_valid  = bv;
        br_cond   = cc;
    endtask

    // Entered at posedge+1 with inputs applied; leaves at the next posedge+1.
    task automatic cycle(input string tag);
        bit c, rdy, tk, en, ez, ev;
        #1;
        c   = ex_valid && !ex_stall && !ex_flush && !m_halt;
        en  = (c && writes_nv(ex_opcode)) ? ex_flags[2] : m_n;
        ez  = (c && writes_z(ex_opcode))  ? ex_flags[1] : m_z;
        ev  = (c && writes_nv(ex_opcode)) ? ex_flags[0] : m_v;
        rdy = !m_halt && !(ex_valid && !ex_flush && ex_stall && writes_z(ex_opcode));
        tk  = br_valid && rdy && cond_of(br_cond, en, ez, ev);
        obs_rdy = br_ready;
        obs_tk  = br_taken;
        chk({tag, ".ready"}, br_ready, rdy);
        chk({tag, ".taken"}, br_taken, tk);
        @(posedge clk);
        #1;
        if (c) begin
            m_n = en;
            m_z = ez;
            m_v = ev;
            if (ex_opcode == HLT) m_halt = 1'b1;
        end
        chk({tag, ".flags"}, {N_flag, Z_flag, V_flag}, {m_n, m_z, m_v});
        chk({tag, ".halted"}, halted, m_halt);
    endtask

    // Pulses rst between clock edges and checks the asynchronous clear.
    task automatic mid_reset(input string tag);
        drive(0, 0, 0, 4'h0, 3'b000, 0, 3'b000);
        #2;
        rst = 1'b1;
        #1;
        chk({tag, ".flags"}, {N_flag, Z_flag, V_flag}, 3'b000);
        chk({tag, ".halted"}, halted, 1'b0);
        rst = 1'b0;
        {m_n, m_z, m_v, m_halt} = 4'b0000;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 4'h0, 3'b000, 0, 3'b000);
        {m_n, m_z, m_v, m_halt} = 4'b0000;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset.flags", {N_flag, Z_flag, V_flag}, 3'b000);
        chk("reset.halted", halted, 1'b0);
        chk("reset.ready", br_ready, 1'b1);

        drive(1, 0, 0, ADD, 3'b101, 1, CC_OV);
        cycle("add");
        chk("add.bypass_ready", obs_rdy, 1'b1);
        chk("add.bypass_taken", obs_tk, 1'b1);
        chk("add.flags_101", {N_flag, Z_flag, V_flag}, 3'b101);

        drive(1, 0, 0, XOR, 3'b010, 0, CC_NE);
        cycle("xor");
        chk("xor.flags_111", {N_flag, Z_flag, V_flag}, 3'b111);
        drive(1, 0, 0, SLL, 3'b000, 0, CC_NE);
        cycle("sll");
        chk("sll.flags_101", {N_flag, Z_flag, V_flag}, 3'b101);

        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, SUB, 3'b010, 1, CC_EQ);
            cycle("sub_stall");
            chk("sub_stall.ready0", obs_rdy, 1'b0);
        end
        drive(1, 0, 0, SUB, 3'b010, 1, CC_EQ);
        cycle("sub_go");
        chk("sub_go.ready", obs_rdy, 1'b1);
        chk("sub_go.taken", obs_tk, 1'b1);
        chk("sub_go.flags_010", {N_flag, Z_flag, V_flag}, 3'b010);

        drive(1, 1, 1, ADD, 3'b111, 1, CC_EQ);
        cycle("flush_eq");
        chk("flush_eq.ready", obs_rdy, 1'b1);
        chk("flush_eq.taken", obs_tk, 1'b1);
        drive(1, 1, 1, ADD, 3'b111, 1, CC_LT);
        cycle("flush_lt");
        chk("flush_lt.taken", obs_tk, 1'b0);
        chk("flush.flags_010", {N_flag, Z_flag, V_flag}, 3'b010);

        drive(1, 0, 0, HLT, 3'b111, 1, CC_AL);
        cycle("hlt");
        chk("hlt.taken", obs_tk, 1'b1);
        chk("hlt.halted", halted, 1'b1);
        drive(1, 0, 0, ADD, 3'b111, 1, CC_AL);
        cycle("post_hlt");
        chk("post_hlt.ready", obs_rdy, 1'b0);
        chk("post_hlt.flags_010", {N_flag, Z_flag, V_flag}, 3'b010);
        mid_reset("hlt_reset");

        for (int f = 0; f < 8; f++) begin
            drive(1, 0, 0, ADD, f[2:0], 0, CC_NE);
            cycle("sweep_load");
            for (int c = 0; c < 8; c++) begin
                drive(0, $urandom_range(0, 1), 0, 4'($urandom_range(0, 15)), 3'($urandom),
                      1, c[2:0]);
                cycle("sweep");
            end
        end

        for (int i = 0; i < 400; i++) begin
            if (m_halt && $urandom_range(0, 3) == 0) begin
                mid_reset("rand_reset");
            end
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 6) == 0, 4'($urandom_range(0, 15)), 3'($urandom),
                  $urandom_range(0, 1) == 1, 3'($urandom));
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
